// File: rtl/motor_pwm_sequencer_pkg.sv
// motor_pwm_sequencer_pkg: shared state encoding and width helper for the motor PWM sequencer
package motor_pwm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DEAD  = 2'd2,
        BRAKE = 2'd3
    } state_t;

    function automatic int cnt_width(input int top);
        return (top > 1) ? $clog2(top) : 1;
    endfunction

endpackage

// File: rtl/motor_pwm_sequencer_tick.sv
// ramp_tick_gen: free-running divider producing a one-cycle ramp tick every RAMP_DIV clocks
module ramp_tick_gen #(
    parameter int RAMP_DIV = 4096
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(RAMP_DIV);
    localparam logic [W-1:0] LAST = W'(RAMP_DIV - 1);

    logic [W-1:0] cnt;

    // count 0..RAMP_DIV-1 and wrap; the tick marks the terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_pwm_sequencer.sv
// motor_pwm_sequencer: ramps PWM duty toward a signed speed target with dead time on reversal and brake
module motor_pwm_sequencer
    import motor_pwm_sequencer_pkg::*;
#(
    parameter  int TOP      = 1024,
    parameter  int STEP     = 8,
    parameter  int RAMP_DIV = 4096,
    parameter  int DEAD_TK  = 4,
    localparam int CNT_W    = cnt_width(TOP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W:0]   cmd_speed,
    input  logic             brake,
    output logic [CNT_W-1:0] duty,
    output logic             dir,
    output logic             at_target,
    output logic             busy
);

    localparam int CW1 = CNT_W + 1;
    localparam int DW  = $clog2(DEAD_TK + 1);
    localparam logic [CNT_W-1:0] MAX_DUTY = CNT_W'(TOP - 1);
    localparam logic [CNT_W:0]   STEP_W   = CW1'(STEP);
    localparam logic [DW-1:0]    DEAD_LD  = DW'(DEAD_TK);

    state_t           state;
    logic [DW-1:0]    dead_cnt;
    logic [CNT_W-1:0] mag;
    logic             tgt_dir;
    logic             tick;
    logic [CNT_W:0]   abs_speed;
    logic [CNT_W:0]   up_sum;
    logic [CNT_W:0]   down_diff;
    logic [CNT_W-1:0] new_mag;
    logic [CNT_W-1:0] duty_up;
    logic [CNT_W-1:0] duty_down;

    ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // magnitude of the command; -2^CNT_W negates to itself and is caught by the saturation
    assign abs_speed = cmd_speed[CNT_W] ? -cmd_speed : cmd_speed;
    assign new_mag   = (abs_speed > {1'b0, MAX_DUTY}) ? MAX_DUTY : abs_speed[CNT_W-1:0];

    // one extra bit keeps the step arithmetic from wrapping
    assign up_sum    = {1'b0, duty} + STEP_W;
    assign duty_up   = (up_sum > {1'b0, mag}) ? mag : up_sum[CNT_W-1:0];
    assign down_diff = {1'b0, duty} - STEP_W;
    assign duty_down = ({1'b0, duty} <= STEP_W) ? '0 : down_diff[CNT_W-1:0];

    assign at_target = (state == IDLE || state == RAMP) && duty == mag && dir == tgt_dir;
    assign busy      = (state == RAMP || state == DEAD);

    // sequencer FSM: target capture, ramp datapath, dead time and brake override
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            duty      <= '0;
            dir       <= 1'b0;
            mag       <= '0;
            tgt_dir   <= 1'b0;
            dead_cnt  <= '0;
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= !brake;
            if (brake) begin
                state <= BRAKE;
                duty  <= '0;
                mag   <= '0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    mag     <= new_mag;
                    tgt_dir <= (new_mag == '0) ? dir : cmd_speed[CNT_W];
                end
                case (state)
                    IDLE: begin
                        if (mag != '0) begin
                            state    <= (tgt_dir == dir) ? RAMP : DEAD;
                            dead_cnt <= DEAD_LD;
                        end
                    end
                    RAMP: begin
                        if (tick) begin
                            if (tgt_dir != dir) begin
                                if (duty == '0) begin
                                    state    <= DEAD;
                                    dead_cnt <= DEAD_LD;
                                end else begin
                                    duty <= duty_down;
                                end
                            end else if (duty < mag) begin
                                duty <= duty_up;
                            end else if (duty > mag) begin
                                duty <= (duty_down < mag) ? mag : duty_down;
                            end else if (mag == '0) begin
                                state <= IDLE;
                            end
                        end
                    end
                    DEAD: begin
                        if (tick) begin
                            if (dead_cnt == DW'(1)) begin
                                dir   <= tgt_dir;
                                state <= (mag != '0) ? RAMP : IDLE;
                            end else begin
                                dead_cnt <= dead_cnt - DW'(1);
                            end
                        end
                    end
                    BRAKE: begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_LD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// tb_motor_pwm_sequencer: table-driven check of ramp, reversal, saturation, brake, dead time and reset
module tb_motor_pwm_sequencer;

    typedef struct {
        int rst_before;
        int sel;
        int valid;
        int speed;
        int brk;
        int n;
        int duty;
        int dir;
        int at;
        int busy;
        int rdy;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        valid8, brake8, valid5, brake5;
    logic [10:0] speed8, speed5;
    logic [9:0]  duty8, duty5;
    logic        dir8, at8, busy8, rdy8;
    logic        dir5, at5, busy5, rdy5;

    int checks = 0;
    int errors = 0;
    int ec = 0;
    logic [9:0] pd = '0;
    vec_t vt[$];

    motor_pwm_sequencer #(.TOP(1024), .STEP(8), .RAMP_DIV(4), .DEAD_TK(4)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (valid8),
        .cmd_ready (rdy8),
        .cmd_speed (speed8),
        .brake     (brake8),
        .duty      (duty8),
        .dir       (dir8),
        .at_target (at8),
        .busy      (busy8)
    );

    motor_pwm_sequencer #(.TOP(1024), .STEP(5), .RAMP_DIV(4), .DEAD_TK(4)) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (valid5),
        .cmd_ready (rdy5),
        .cmd_speed (speed5),
        .brake     (brake5),
        .duty      (duty5),
        .dir       (dir5),
        .at_target (at5),
        .busy      (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // duty may only move on tick edges (every 4th edge after reset release) unless braking
    always @(posedge clk) begin
        #1;
        if (reset) begin
            ec = 0;
            pd = '0;
        end else begin
            ec++;
            if (duty8 != pd && !brake8) begin
                checks++;
                if (ec % 4 != 0) begin
                    errors++;
                    $display("FAIL tick_align: duty moved to %0d at edge %0d, expected only on multiples of 4", duty8, ec);
                end
            end
            pd = duty8;
        end
    end

    task automatic add(input int rb, input int sel, input int valid, input int speed, input int brk,
                       input int n, input int duty, input int dir, input int at, input int busy, input int rdy);
        vec_t v;
        v.rst_before = rb; v.sel = sel; v.valid = valid; v.speed = speed; v.brk = brk; v.n = n;
        v.duty = duty; v.dir = dir; v.at = at; v.busy = busy; v.rdy = rdy;
        vt.push_back(v);
    endtask

    // asynchronous reset in the middle of a low clock phase, then re-align to the tick phase
    task automatic do_reset(input int idx);
        #2 reset = 1'b1;
        #1;
        chk("async_duty", idx, int'(duty8), 0);
        chk("async_dir", idx, int'(dir8), 0);
        chk("async_ready", idx, int'(rdy8), 0);
        chk("async_duty5", idx, int'(duty5), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input vec_t v, input int idx);
        if (v.rst_before != 0) do_reset(idx);
        if (v.sel != 0) begin
            valid5 = v.valid[0];
            speed5 = 11'(v.speed);
        end else begin
            valid8 = v.valid[0];
            speed8 = 11'(v.speed);
            brake8 = v.brk[0];
        end
        for (int i = 0; i < 4 * v.n; i++) begin
            @(posedge clk);
            @(negedge clk);
            valid8 = 1'b0;
            valid5 = 1'b0;
        end
        if (v.sel != 0) begin
            chk("duty", idx, int'(duty5), v.duty);
            chk("dir", idx, int'(dir5), v.dir);
            chk("at_target", idx, int'(at5), v.at);
            chk("busy", idx, int'(busy5), v.busy);
            chk("cmd_ready", idx, int'(rdy5), v.rdy);
        end else begin
            chk("duty", idx, int'(duty8), v.duty);
            chk("dir", idx, int'(dir8), v.dir);
            chk("at_target", idx, int'(at8), v.at);
            chk("busy", idx, int'(busy8), v.busy);
            chk("cmd_ready", idx, int'(rdy8), v.rdy);
        end
    endtask

    initial begin
        //   rb sel val speed brk  n  duty dir at busy rdy
        add(0, 0, 0,     0, 0,   1,    0, 0, 1, 0, 1);
        add(0, 0, 1,   100, 0,   1,    8, 0, 0, 1, 1);
        add(0, 0, 0,     0, 0,   5,   48, 0, 0, 1, 1);
        add(0, 0, 0,     0, 0,   7,  100, 0, 1, 1, 1);
        add(0, 0, 0,     0, 0,   2,  100, 0, 1, 1, 1);
        add(0, 0, 1,   -40, 0,   1,   92, 0, 0, 1, 1);
        add(0, 0, 0,     0, 0,  12,    0, 0, 0, 1, 1);
        add(0, 0, 0,     0, 0,   1,    0, 0, 0, 1, 1);
        add(0, 0, 0,     0, 0,   3,    0, 0, 0, 1, 1);
        add(0, 0, 0,     0, 0,   1,    0, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0,   5,   40, 1, 1, 1, 1);
        add(0, 0, 1, -1024, 0,   1,   48, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0, 121, 1016, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0,   1, 1023, 1, 1, 1, 1);
        add(0, 0, 0,     0, 0,   3, 1023, 1, 1, 1, 1);
        add(0, 0, 1,  -500, 0,   1, 1015, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0,  65,  500, 1, 1, 1, 1);
        add(0, 0, 1, -1000, 0,   1,  508, 1, 0, 1, 1);
        add(0, 0, 1,   300, 1,   1,    0, 1, 0, 0, 0);
        add(0, 0, 1,   300, 1,   2,    0, 1, 0, 0, 0);
        add(0, 0, 0,     0, 0,   1,    0, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0,   2,    0, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0,   1,    0, 1, 1, 0, 1);
        add(0, 0, 1,    64, 0,   1,    0, 1, 0, 1, 1);
        add(0, 0, 1,     0, 0,   1,    0, 1, 0, 1, 1);
        add(0, 0, 0,     0, 0,   2,    0, 1, 1, 0, 1);
        add(0, 0, 1,  -200, 0,   3,   24, 1, 0, 1, 1);
        add(1, 1, 1,    12, 0,   1,    5, 0, 0, 1, 1);
        add(0, 1, 0,     0, 0,   1,   10, 0, 0, 1, 1);
        add(0, 1, 0,     0, 0,   1,   12, 0, 1, 1, 1);
        add(0, 1, 0,     0, 0,   2,   12, 0, 1, 1, 1);

        valid8 = 1'b0; brake8 = 1'b0; speed8 = '0;
        valid5 = 1'b0; brake5 = 1'b0; speed5 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_duty", -1, int'(duty8), 0);
        chk("rst_dir", -1, int'(dir8), 0);
        chk("rst_ready", -1, int'(rdy8), 0);
        chk("rst_busy", -1, int'(busy8), 0);
        chk("rst_at_target", -1, int'(at8), 1);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        foreach (vt[i]) run(vt[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
